// File: rtl/ternary_neuron_acc.sv
// Ternary neuron accumulator: sums (pc_pos - pc_neg) over NBEATS beats with symmetric
// saturation, then thresholds the sum into a {-1, 0, +1} activation behind valid/ready.
module ternary_neuron_acc #(
  parameter int NBEATS = 4,
  parameter int ACC_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       pc_pos,
  input  logic [3:0]       pc_neg,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_act,
  output logic [ACC_W-1:0] out_sum
);

  typedef enum logic {ACCUM, RESULT} state_t;

  localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  // Wide enough for any saturated sum plus a full -15..+15 step without wrapping.
  localparam int SUM_W = ((ACC_W > 5) ? ACC_W : 5) + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;
  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(NBEATS - 1);

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d;
  logic [1:0]                act_q, act_d;
  logic signed [ACC_W-1:0]   sum_q, sum_d;

  logic signed [SUM_W-1:0]   diff, sum_wide;
  logic signed [ACC_W-1:0]   sum_sat, hi_eff, lo_eff;
  logic                      beat_fire;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == RESULT);
  assign out_act   = act_q;
  assign out_sum   = sum_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    thr_hi_d = thr_hi_q;
    thr_lo_d = thr_lo_q;
    act_d    = act_q;
    sum_d    = sum_q;

    beat_fire = in_valid && (state_q == ACCUM);
    diff      = $signed({{(SUM_W-4){1'b0}}, pc_pos}) - $signed({{(SUM_W-4){1'b0}}, pc_neg});
    sum_wide  = $signed({{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}) + diff;
    if (sum_wide > SAT_MAX)      sum_sat = ACC_W'(SAT_MAX);
    else if (sum_wide < SAT_MIN) sum_sat = ACC_W'(SAT_MIN);
    else                         sum_sat = ACC_W'(sum_wide);

    // The first beat of a frame uses the live thresholds, so NBEATS=1 works too.
    hi_eff = (cnt_q == '0) ? $signed(thr_hi) : thr_hi_q;
    lo_eff = (cnt_q == '0) ? $signed(thr_lo) : thr_lo_q;

    case (state_q)
      ACCUM: begin
        if (beat_fire) begin
          if (cnt_q == '0) begin
            thr_hi_d = $signed(thr_hi);
            thr_lo_d = $signed(thr_lo);
          end
          if (cnt_q == LAST) begin
            sum_d   = sum_sat;
            if (sum_sat > hi_eff)      act_d = 2'b01;
            else if (sum_sat < lo_eff) act_d = 2'b11;
            else                       act_d = 2'b00;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RESULT;
          end else begin
            acc_d = sum_sat;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESULT: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      thr_hi_q <= '0;
      thr_lo_q <= '0;
      act_q    <= 2'b00;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
      act_q    <= act_d;
      sum_q    <= sum_d;
    end
  end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Directed bench for ternary_neuron_acc: an 8-bit and a 6-bit accumulator share the
// same beat stream; expected sums and activations are hand-computed constants.
module tb_ternary_neuron_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] pc_pos, pc_neg;
  logic [7:0] thr_hi, thr_lo;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [1:0] out_act;
  logic [7:0] out_sum;

  logic [5:0] thr_hi6, thr_lo6;
  logic       in_ready6, out_valid6;
  logic [1:0] out_act6;
  logic [5:0] out_sum6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ternary_neuron_acc #(.NBEATS(4), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_pos(pc_pos), .pc_neg(pc_neg), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_sum(out_sum)
  );

  ternary_neuron_acc #(.NBEATS(4), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .pc_pos(pc_pos), .pc_neg(pc_neg), .thr_hi(thr_hi6), .thr_lo(thr_lo6),
    .out_valid(out_valid6), .out_ready(out_ready), .out_act(out_act6), .out_sum(out_sum6)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Offer one beat and return at the falling edge after it is accepted.
  task automatic beat(input int p, input int n);
    int t;
    t = 0;
    pc_pos   = 4'(p);
    pc_neg   = 4'(n);
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("beat_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame4(input int p, input int n);
    for (int i = 0; i < 4; i++) beat(p, n);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pop_in_ready", int'(in_ready), 1);
    check("pop_out_valid", int'(out_valid), 0);
  endtask

  task automatic expect_result(input string tag, input int sum, input int act);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_sum"}, int'($signed(out_sum)), sum);
    check({tag, "_act"}, int'(out_act), act);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_pos = '0; pc_neg = '0;
    thr_hi = 8'sd2; thr_lo = -8'sd2;
    thr_hi6 = 6'sd2; thr_lo6 = -6'sd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_act", int'(out_act), 0);
    check("rst_sum", int'($signed(out_sum)), 0);

    // 4 + 0 - 2 + 8 = 10 > 2
    beat(5, 1); beat(3, 3); beat(0, 2); beat(8, 0);
    expect_result("basic", 10, 1);
    pop();

    frame4(0, 8);
    expect_result("neg", -32, 3);
    pop();

    // Exactly on each threshold: strict compare gives 0.
    beat(2, 0); beat(0, 0); beat(0, 0); beat(0, 0);
    expect_result("eq_hi", 2, 0);
    pop();
    beat(0, 2); beat(0, 0); beat(0, 0); beat(0, 0);
    expect_result("eq_lo", -2, 0);
    pop();

    // Backpressure: result held, offered beats ignored.
    frame4(1, 0);
    pc_pos = 4'd7; pc_neg = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_result("hold", 4, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop();
    frame4(1, 1);
    expect_result("after_hold", 0, 0);
    pop();

    // Threshold latch: thr_hi=0 captured on first beat; later change to 20 ignored.
    thr_hi = 8'sd0;
    beat(4, 0);
    thr_hi = 8'sd20;
    beat(2, 0); beat(2, 0); beat(2, 0);
    expect_result("thr_latch", 10, 1);
    pop();

    // Inverted thresholds: +1 test has priority.
    thr_hi = -8'sd5; thr_lo = 8'sd5;
    frame4(0, 0);
    expect_result("thr_prio", 0, 1);
    pop();
    thr_hi = 8'sd2; thr_lo = -8'sd2;

    // Saturation in the 6-bit instance, none in the 8-bit one.
    frame4(15, 0);
    expect_result("sat_pos8", 60, 1);
    check("sat_pos6_valid", int'(out_valid6), 1);
    check("sat_pos6_sum", int'($signed(out_sum6)), 31);
    check("sat_pos6_act", int'(out_act6), 1);
    pop();
    frame4(0, 15);
    expect_result("sat_neg8", -60, 3);
    check("sat_neg6_sum", int'($signed(out_sum6)), -31);
    check("sat_neg6_act", int'(out_act6), 3);
    pop();

    // Reset mid-frame discards the partial sum.
    beat(8, 0); beat(8, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_in_ready", int'(in_ready), 1);
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_act", int'(out_act), 0);
    check("mrst_sum", int'($signed(out_sum)), 0);
    frame4(1, 0);
    expect_result("mrst_frame", 4, 1);
    pop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
